dr_alm_pipe: RTL and testbench

- Parametrised, 3-stage pipelined Dynamic Range Approximate Logarithmic Multiplier (DR-ALM-t) with valid/ready handshakes on both sides.
- Generalised in operand width and truncation width.
- Per-transaction signed/unsigned mode and a pass-through tag.
- Sits between operand fetch and accumulator in the approximate MAC datapath; supports full throughput and back-pressure.

---
 rtl/dr_alm_pipe.sv | 172 +++++++++++++++++
 tb/tb_dr_alm_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_alm_pipe.sv
// rtl/dr_alm_pipe.sv - 3-stage pipelined dynamic-range approximate logarithmic multiplier (DR-ALM-t)
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_valid, o_ready         operand-side handshake
//   i_a, i_b [WIDTH]         operands
//   i_signed                 1 = two's complement operands, 0 = unsigned
//   i_tag [TAG_WIDTH]        sideband returned with the result
//   o_valid, i_ready         result-side handshake
//   o_z [2*WIDTH]            approximate product
//   o_tag [TAG_WIDTH]        tag of the result
module dr_alm_pipe #(
    parameter int WIDTH       = 16,
    parameter int TRUNC_WIDTH = 6,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_a,
    input  logic [WIDTH-1:0]       i_b,
    input  logic                   i_signed,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [2*WIDTH-1:0]     o_z,
    output logic [TAG_WIDTH-1:0]   o_tag
);

    localparam int KW = $clog2(WIDTH);
    localparam int SW = KW + 1;
    localparam int ZW = 2 * WIDTH;
    localparam int T  = TRUNC_WIDTH;
    localparam logic [KW-1:0] KMAX  = KW'(WIDTH - 1);
    localparam logic [SW-1:0] SHMAX = SW'(ZW - 1);

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sg);
        f_mag = (sg && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [KW-1:0] f_lead(input logic [WIDTH-1:0] v);
        f_lead = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) f_lead = KW'(i);
        end
    endfunction

    // Upper t-1 fraction bits below the leading one. The truncated fraction's
    // forced low 1 is not stored; it is folded into the stage-2 adder.
    function automatic logic [T-2:0] f_xh(input logic [WIDTH-1:0] v, input logic [KW-1:0] k);
        logic [WIDTH-1:0] norm;
        norm = v << (KMAX - k);
        f_xh = (T-1)'(norm >> (WIDTH - T));
    endfunction

    // ---------------- handshake ----------------
    logic r_v1, r_v2, r_v3;
    logic w_adv1, w_adv2, w_adv3;

    assign w_adv3  = !r_v3 || i_ready;
    assign w_adv2  = !r_v2 || w_adv3;
    assign w_adv1  = !r_v1 || w_adv2;
    assign o_ready = w_adv1;

    // ---------------- stage 1 logic ----------------
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [KW-1:0]    w_ka, w_kb;
    logic [T-2:0]     w_xa, w_xb;
    logic             w_s, w_zero;

    assign w_mag_a = f_mag(i_a, i_signed);
    assign w_mag_b = f_mag(i_b, i_signed);
    assign w_ka    = f_lead(w_mag_a);
    assign w_kb    = f_lead(w_mag_b);
    assign w_xa    = f_xh(w_mag_a, w_ka);
    assign w_xb    = f_xh(w_mag_b, w_kb);
    assign w_s     = i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    assign w_zero  = (w_mag_a == '0) || (w_mag_b == '0);

    logic                 r_s1, r_zero1;
    logic [KW-1:0]        r_ka1, r_kb1;
    logic [T-2:0]         r_xa1, r_xb1;
    logic [TAG_WIDTH-1:0] r_tag1;

    // ---------------- stage 2 logic ----------------
    // With xt = {xh, 1}: (xt_a + xt_b + 1) >> 1 == xh_a + xh_b + 1, and the
    // dropped LSB of the full sum is always 1, so w_hs is sum[t:1].
    logic [T-1:0]  w_hs;
    logic [SW-1:0] w_ks;
    logic [T-1:0]  w_m;

    assign w_hs = {1'b0, r_xa1} + {1'b0, r_xb1} + {{(T-1){1'b0}}, 1'b1};
    assign w_ks = {1'b0, r_ka1} + {1'b0, r_kb1} + {{KW{1'b0}}, w_hs[T-1]};
    assign w_m  = {1'b1, w_hs[T-2:0]};

    logic                 r_s2, r_zero2;
    logic [SW-1:0]        r_ks2;
    logic [T-1:0]         r_m2;
    logic [TAG_WIDTH-1:0] r_tag2;

    // ---------------- stage 3 logic ----------------
    logic [SW-1:0] w_sh;
    logic [ZW-1:0] w_p, w_z;

    assign w_sh = SHMAX - r_ks2;
    assign w_p  = {r_m2, {(ZW-T){1'b0}}} >> w_sh;
    assign w_z  = r_zero2 ? '0 : (r_s2 ? -w_p : w_p);

    logic [ZW-1:0]        r_z3;
    logic [TAG_WIDTH-1:0] r_tag3;

    assign o_valid = r_v3;
    assign o_z     = r_z3;
    assign o_tag   = r_tag3;

    // ---------------- pipeline registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v1   <= 1'b0;
            r_s1   <= 1'b0;
            r_zero1<= 1'b0;
            r_ka1  <= '0;
            r_kb1  <= '0;
            r_xa1  <= '0;
            r_xb1  <= '0;
            r_tag1 <= '0;
            r_v2   <= 1'b0;
            r_s2   <= 1'b0;
            r_zero2<= 1'b0;
            r_ks2  <= '0;
            r_m2   <= '0;
            r_tag2 <= '0;
            r_v3   <= 1'b0;
            r_z3   <= '0;
            r_tag3 <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= i_valid;
                if (i_valid) begin
                    r_s1    <= w_s;
                    r_zero1 <= w_zero;
                    r_ka1   <= w_ka;
                    r_kb1   <= w_kb;
                    r_xa1   <= w_xa;
                    r_xb1   <= w_xb;
                    r_tag1  <= i_tag;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_s2    <= r_s1;
                    r_zero2 <= r_zero1;
                    r_ks2   <= w_ks;
                    r_m2    <= w_m;
                    r_tag2  <= r_tag1;
                end
            end
            // Result registers only load with a real operation, so o_z/o_tag
            // hold while stalled and across bubbles.
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_z3   <= w_z;
                    r_tag3 <= r_tag2;
                end
            end
        end
    end

endmodule

// File: tb/tb_dr_alm_pipe.sv
// tb/tb_dr_alm_pipe.sv - self-checking bench for dr_alm_pipe (16/6, 8/3 and 32/10 instances)
module tb_dr_alm_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        v16, rdy16, s16, ov16, ir16;
    logic [15:0] a16, b16;
    logic [3:0]  tg16, ot16;
    logic [31:0] z16;

    logic        v8, rdy8, s8, ov8;
    logic [7:0]  a8, b8;
    logic [3:0]  tg8, ot8;
    logic [15:0] z8;

    logic        v32, rdy32, s32, ov32;
    logic [31:0] a32, b32;
    logic [3:0]  tg32, ot32;
    logic [63:0] z32;

    dr_alm_pipe #(.WIDTH(16), .TRUNC_WIDTH(6), .TAG_WIDTH(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(rdy16), .i_a(a16), .i_b(b16),
        .i_signed(s16), .i_tag(tg16), .o_valid(ov16), .i_ready(ir16), .o_z(z16), .o_tag(ot16));

    dr_alm_pipe #(.WIDTH(8), .TRUNC_WIDTH(3), .TAG_WIDTH(4)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8), .i_a(a8), .i_b(b8),
        .i_signed(s8), .i_tag(tg8), .o_valid(ov8), .i_ready(1'b1), .o_z(z8), .o_tag(ot8));

    dr_alm_pipe #(.WIDTH(32), .TRUNC_WIDTH(10), .TAG_WIDTH(4)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(rdy32), .i_a(a32), .i_b(b32),
        .i_signed(s32), .i_tag(tg32), .o_valid(ov32), .i_ready(1'b1), .o_z(z32), .o_tag(ot32));

    typedef struct {
        logic [63:0] z;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t q32[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit lat_chk = 0;
    bit use_dir = 0;
    logic [63:0] dir_z;
    bit stall_prev = 0;
    logic [31:0] hz;
    logic [3:0]  ht;
    bit acc16;

    // Reference: log-domain approximation from the operand magnitudes,
    // computed with plain integer arithmetic.
    function automatic logic [63:0] alm(input int n, input int t, input logic [63:0] a,
                                        input logic [63:0] b, input bit sg);
        logic [63:0] mn, ma, mb, xa, xb, sum, m, p;
        int ka, kb, ks;
        bit neg;
        mn = (64'd1 << n) - 64'd1;
        ma = a & mn;
        mb = b & mn;
        neg = 0;
        if (sg && ma[n-1]) begin ma = (-ma) & mn; neg = !neg; end
        if (sg && mb[n-1]) begin mb = (-mb) & mn; neg = !neg; end
        if (ma == 64'd0 || mb == 64'd0) return 64'd0;
        ka = 0;
        while ((ma >> (ka + 1)) != 64'd0) ka++;
        kb = 0;
        while ((mb >> (kb + 1)) != 64'd0) kb++;
        xa = ((((ma - (64'd1 << ka)) << (n - 1 - ka)) >> (n - t)) << 1) | 64'd1;
        xb = ((((mb - (64'd1 << kb)) << (n - 1 - kb)) >> (n - t)) << 1) | 64'd1;
        sum = xa + xb + 64'd1;
        ks = ka + kb + ((sum >= (64'd1 << t)) ? 1 : 0);
        m = (64'd1 << (t - 1)) + ((sum % (64'd1 << t)) >> 1);
        p = (m << (2 * n - t)) >> (2 * n - 1 - ks);
        if (neg) p = -p;
        if (2 * n < 64) p = p & ((64'd1 << (2 * n)) - 64'd1);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (stall_prev) begin
            chk("hold_valid", 64'(ov16), 64'd1);
            chk("hold_z", 64'(z16), 64'(hz));
            chk("hold_tag", 64'(ot16), 64'(ht));
        end
        stall_prev = ov16 && !ir16;
        hz = z16;
        ht = ot16;
        if (ov16 && ir16) begin
            chk("pending16", 64'(q16.size() > 0), 64'd1);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("z16", 64'(z16), e.z);
                chk("tag16", 64'(ot16), 64'(e.tag));
                if (lat_chk) chk("latency16", 64'(cyc - e.cyc), 64'd3);
            end
        end
        acc16 = v16 && rdy16;
        if (acc16) begin
            e.z = use_dir ? dir_z : alm(16, 6, 64'(a16), 64'(b16), s16);
            e.tag = tg16;
            e.cyc = cyc;
            q16.push_back(e);
        end
        if (ov8) begin
            chk("pending8", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("z8", 64'(z8), e.z);
                chk("tag8", 64'(ot8), 64'(e.tag));
            end
        end
        if (v8 && rdy8) begin
            e.z = alm(8, 3, 64'(a8), 64'(b8), s8);
            e.tag = tg8;
            e.cyc = cyc;
            q8.push_back(e);
        end
        if (ov32) begin
            chk("pending32", 64'(q32.size() > 0), 64'd1);
            if (q32.size() > 0) begin
                e = q32.pop_front();
                chk("z32", z32, e.z);
                chk("tag32", 64'(ot32), 64'(e.tag));
            end
        end
        if (v32 && rdy32) begin
            e.z = alm(32, 10, 64'(a32), 64'(b32), s32);
            e.tag = tg32;
            e.cyc = cyc;
            q32.push_back(e);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sg,
                        input logic [3:0] tg, input bit dir, input logic [63:0] dz);
        a16 = a; b16 = b; s16 = sg; tg16 = tg; v16 = 1'b1;
        use_dir = dir; dir_z = dz;
        tick();
    endtask

    task automatic drain(input int budget);
        v16 = 1'b0; v8 = 1'b0; v32 = 1'b0; ir16 = 1'b1;
        for (int i = 0; i < budget; i++) tick();
        chk("drained16", 64'(q16.size()), 64'd0);
    endtask

    initial begin
        int sent;
        bit hold;
        rst = 1'b1;
        v16 = 0; a16 = 0; b16 = 0; s16 = 0; tg16 = 0; ir16 = 1;
        v8 = 0; a8 = 0; b8 = 0; s8 = 0; tg8 = 0;
        v32 = 0; a32 = 0; b32 = 0; s32 = 0; tg32 = 0;
        #1;
        chk("rst_valid", 64'(ov16), 64'd0);
        chk("rst_ready", 64'(rdy16), 64'd1);
        chk("rst_z", 64'(z16), 64'd0);
        chk("rst_tag", 64'(ot16), 64'd0);
        chk("rst_z8", 64'(z8), 64'd0);
        chk("rst_z32", z32, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed unsigned stream, full throughput, exact 3-cycle latency.
        lat_chk = 1;
        op16(16'd1, 16'd1, 1'b0, 4'd1, 1, 64'd1);
        op16(16'd2, 16'd2, 1'b0, 4'd2, 1, 64'd4);
        op16(16'd3, 16'd3, 1'b0, 4'd3, 1, 64'd8);
        op16(16'hFFFF, 16'hFFFF, 1'b0, 4'd4, 1, 64'hFC000000);
        op16(16'd0, 16'd1234, 1'b0, 4'd5, 1, 64'd0);
        drain(5);

        // Directed signed.
        op16(16'hFFFD, 16'd3, 1'b1, 4'd6, 1, 64'hFFFFFFF8);
        op16(16'hFFFD, 16'hFFFD, 1'b1, 4'd7, 1, 64'd8);
        op16(16'h8000, 16'd1, 1'b1, 4'd8, 0, 64'd0);
        op16(16'd0, 16'hFFFB, 1'b1, 4'd9, 1, 64'd0);
        op16(16'hFFFB, 16'd0, 1'b1, 4'd10, 1, 64'd0);
        use_dir = 0;
        drain(5);
        lat_chk = 0;

        // Back-pressure: 10 ops, i_ready low for 5 cycles mid-stream.
        sent = 0;
        hold = 0;
        for (int c = 0; c < 40 && sent < 10; c++) begin
            ir16 = !(c >= 4 && c < 9);
            if (!hold) begin
                a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom); tg16 = 4'(sent);
            end
            v16 = 1'b1;
            #1;
            if (c == 6) begin
                chk("full_oready", 64'(rdy16), 64'd0);
                chk("full_ovalid", 64'(ov16), 64'd1);
            end
            tick();
            if (acc16) sent++;
            hold = !acc16;
        end
        chk("bp_sent", 64'(sent), 64'd10);
        drain(8);

        // Random valid/ready toggling.
        for (int i = 0; i < 400; i++) begin
            v16 = 1'($urandom); ir16 = ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom >> $urandom_range(0, 16)); b16 = 16'($urandom);
            s16 = 1'($urandom); tg16 = 4'($urandom);
            tick();
        end
        drain(10);

        // Asynchronous reset between edges with 3 ops in flight.
        ir16 = 1'b0;
        for (int i = 0; i < 3; i++) op16(16'($urandom), 16'($urandom), 1'b0, 4'(i + 11), 0, 64'd0);
        v16 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(ov16), 64'd0);
        chk("arst_z", 64'(z16), 64'd0);
        chk("arst_tag", 64'(ot16), 64'd0);
        chk("arst_ready", 64'(rdy16), 64'd1);
        q16.delete();
        stall_prev = 0;
        ir16 = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_valid", 64'(ov16), 64'd0);
        chk("post_rst_ready", 64'(rdy16), 64'd1);

        // Parameter sweep: 8-bit exhaustive, 32-bit random, 16-bit unsigned random.
        a32 = 32'h80000000; b32 = 32'h80000000; s32 = 1'b0; tg32 = 4'd1; v32 = 1'b1;
        a8 = 8'h80; b8 = 8'h80; s8 = 1'b1; tg8 = 4'd2; v8 = 1'b1;
        tick();
        v16 = 1'b1; s16 = 1'b0; ir16 = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            a8 = 8'(i); b8 = 8'(i >> 8); s8 = 1'($urandom); tg8 = 4'(i);
            a32 = $urandom >> $urandom_range(0, 31); b32 = $urandom >> $urandom_range(0, 31);
            s32 = 1'($urandom); tg32 = 4'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); tg16 = 4'(i >> 4);
            tick();
        end
        drain(6);
        chk("drained8", 64'(q8.size()), 64'd0);
        chk("drained32", 64'(q32.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
